// File: rtl/fetch_predict_unit_pkg.sv
// Shared definitions for the fetch/predict slice.
//   DEF_* constants : default widths, increment and reset address
//   ctr_t           : 2-bit bimodal predictor states
//   ctr_step        : saturating counter move toward taken/not-taken
package fetch_predict_unit_pkg;

    localparam int              DEF_XLEN        = 32;
    localparam int              DEF_BTB_ENTRIES = 16;
    localparam int              DEF_INC         = 4;
    localparam logic [31:0]     DEF_RESET_PC    = 32'h0000_0000;
    localparam int              DEF_CNT_W       = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic ctr_t ctr_step(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = ctr_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_predict_unit_if.sv
// Fetch/predict bus: hazard stall in, fetch address and prediction out,
// resolved-instruction update from EX/MEM in, redirect and counter out.
//   master : the fetch/predict unit
//   slave  : the surrounding pipeline (or a testbench)
interface fetch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic [XLEN-1:0]  pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_is_branch;
    logic             upd_is_jump;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;
    logic             redirect;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        input  stall, upd_valid, upd_pc, upd_is_branch, upd_is_jump,
               upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pc, pred_taken, pred_target, redirect, mispredict_cnt
    );

    modport slave (
        output stall, upd_valid, upd_pc, upd_is_branch, upd_is_jump,
               upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pc, pred_taken, pred_target, redirect, mispredict_cnt
    );
endinterface

// File: rtl/fetch_predict_unit_btb.sv
// Direct-mapped bimodal branch target buffer.
//   clk, rst          : clock, async active-high reset (clears every entry)
//   lookup_pc_i       : fetch address; pred_taken_o / pred_target_o answer it
//   upd_en_i          : a resolved branch or jump is presented this cycle
//   upd_is_jump_i     : unconditional (forces strong-taken on hit/allocate)
//   upd_taken_i       : resolved direction (already forced for jumps)
//   upd_pc_i          : address of the resolved instruction
//   upd_target_i      : resolved target
module fetch_predict_unit_btb
    import fetch_predict_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_en_i,
    input  logic            upd_is_jump_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [XLEN-1:0] upd_target_i
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    ctr_t                   ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]   rd_idx, up_idx;
    logic [TAG_W-1:0] rd_tag, up_tag;
    logic             rd_hit, up_hit;

    // Byte-offset bits never select an entry.
    logic unused_offset;
    assign unused_offset = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    assign rd_idx = lookup_pc_i[IDX+1:2];
    assign rd_tag = lookup_pc_i[XLEN-1:IDX+2];
    assign up_idx = upd_pc_i[IDX+1:2];
    assign up_tag = upd_pc_i[XLEN-1:IDX+2];

    // Lookup reads the registered arrays, so a same-cycle update to the
    // same index is only visible from the next cycle on.
    assign rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken_o  = rd_hit && ctr_q[rd_idx][1];
    assign pred_target_o = target_q[rd_idx];
    assign up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= SNT;
            end
        end else if (upd_en_i) begin
            if (up_hit) begin
                if (upd_is_jump_i) begin
                    ctr_q[up_idx]    <= ST;
                    target_q[up_idx] <= upd_target_i;
                end else begin
                    ctr_q[up_idx] <= ctr_step(ctr_q[up_idx], upd_taken_i);
                    if (upd_taken_i) target_q[up_idx] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                // Miss and taken: evict whatever aliases into this slot.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target_i;
                ctr_q[up_idx]    <= upd_is_jump_i ? ST : WT;
            end
        end
    end

endmodule

// File: rtl/fetch_predict_unit.sv
// PC / fetch-address generator with BTB-based prediction.
//   clk, rst : clock, async active-high reset
//   bus      : fetch_predict_unit_if.master (stall, pc, prediction,
//              EX/MEM update, redirect, mispredict counter)
// Next-PC priority: redirect > stall > predicted target > pc + INC.
module fetch_predict_unit
    import fetch_predict_unit_pkg::*;
#(
    parameter int              XLEN        = DEF_XLEN,
    parameter int              BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter int              INC         = DEF_INC,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
    parameter int              CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_predict_unit_if.master bus
);
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            is_ctl;
    logic            taken_act;
    logic            redirect;
    logic [XLEN-1:0] correct_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    fetch_predict_unit_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .upd_en_i      (is_ctl),
        .upd_is_jump_i (bus.upd_is_jump),
        .upd_taken_i   (taken_act),
        .upd_pc_i      (bus.upd_pc),
        .upd_target_i  (bus.upd_target)
    );

    // Updates with neither type bit set carry no control flow and are dropped.
    assign is_ctl    = bus.upd_valid && (bus.upd_is_branch || bus.upd_is_jump);
    assign taken_act = bus.upd_is_jump || bus.upd_taken;

    // A taken prediction is only correct if the target also matched.
    assign redirect = is_ctl &&
                      ((taken_act != bus.upd_pred_taken) ||
                       (taken_act && (bus.upd_target != bus.upd_pred_target)));

    assign correct_pc = taken_act ? bus.upd_target : bus.upd_pc + XLEN'(INC);

    always_comb begin
        pc_d = pc_q + XLEN'(INC);
        if (redirect)        pc_d = correct_pc;
        else if (bus.stall)  pc_d = pc_q;
        else if (pred_taken) pc_d = pred_target;
    end

    assign cnt_d = redirect ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pred_taken     = pred_taken;
    assign bus.pred_target    = pred_target;
    assign bus.redirect       = redirect;
    assign bus.mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_predict_unit.sv
module tb_fetch_predict_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fetch_predict_unit_if #(.XLEN(32), .CNT_W(16)) bus ();

    fetch_predict_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic isb, input logic isj, input logic [31:0] upc,
                           input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        bus.upd_valid       = 1'b1;
        bus.upd_is_branch   = isb;
        bus.upd_is_jump     = isj;
        bus.upd_pc          = upc;
        bus.upd_taken       = tk;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = ptk;
        bus.upd_pred_target = ptgt;
    endtask

    task automatic clr_upd();
        bus.upd_valid       = 1'b0;
        bus.upd_is_branch   = 1'b0;
        bus.upd_is_jump     = 1'b0;
        bus.upd_pc          = '0;
        bus.upd_taken       = 1'b0;
        bus.upd_target      = '0;
        bus.upd_pred_taken  = 1'b0;
        bus.upd_pred_target = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.stall = 1'b0;
        clr_upd();
        #3;
        chk("rst_pc", bus.pc, 64'h0);
        chk("rst_pred", bus.pred_taken, 64'h0);
        chk("rst_redirect", bus.redirect, 64'h0);
        chk("rst_cnt", bus.mispredict_cnt, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // sequential fetch
        step(); chk("seq_pc4", bus.pc, 64'h4);
        step(); chk("seq_pc8", bus.pc, 64'h8);
        step(); chk("seq_pcc", bus.pc, 64'hc);
        chk("seq_pred", bus.pred_taken, 64'h0);
        chk("seq_redirect", bus.redirect, 64'h0);

        // branch 0x40 -> 0x100 taken, predicted not-taken
        set_upd(1, 0, 32'h40, 1, 32'h100, 0, 32'h0);
        #1 chk("br_taken_redirect", bus.redirect, 64'h1);
        step(); clr_upd();
        chk("br_taken_pc", bus.pc, 64'h100);
        chk("br_taken_cnt", bus.mispredict_cnt, 64'h1);
        // mispredict at 0x3c (not taken) steers fetch to 0x40
        set_upd(1, 0, 32'h3c, 0, 32'h0, 1, 32'h40);
        step(); clr_upd();
        chk("steer40_pc", bus.pc, 64'h40);
        chk("steer40_cnt", bus.mispredict_cnt, 64'h2);
        #1 chk("hit40_pred", bus.pred_taken, 64'h1);
        chk("hit40_target", bus.pred_target, 64'h100);
        step(); chk("hit40_next_pc", bus.pc, 64'h100);

        // same branch now resolves not taken
        set_upd(1, 0, 32'h40, 0, 32'h100, 1, 32'h100);
        #1 chk("br_nt_redirect", bus.redirect, 64'h1);
        step(); clr_upd();
        chk("br_nt_pc", bus.pc, 64'h44);
        chk("br_nt_cnt", bus.mispredict_cnt, 64'h3);
        set_upd(1, 0, 32'h3c, 0, 32'h0, 1, 32'h40);
        step(); clr_upd();
        chk("steer40b_pc", bus.pc, 64'h40);
        #1 chk("wnt40_pred", bus.pred_taken, 64'h0);
        step(); chk("wnt40_next_pc", bus.pc, 64'h44);

        // redirect beats stall, then stall holds
        bus.stall = 1'b1;
        set_upd(1, 0, 32'h3c, 1, 32'h200, 0, 32'h0);
        #1 chk("stall_redir_redirect", bus.redirect, 64'h1);
        step(); clr_upd();
        chk("stall_redir_pc", bus.pc, 64'h200);
        chk("stall_redir_cnt", bus.mispredict_cnt, 64'h5);
        step(); chk("stall_hold1", bus.pc, 64'h200);
        step(); chk("stall_hold2", bus.pc, 64'h200);
        bus.stall = 1'b0;
        step(); chk("stall_release", bus.pc, 64'h204);

        // aliasing: jump @0x40 then taken branch @0x80 share index 0
        set_upd(0, 1, 32'h40, 0, 32'h300, 0, 32'h0);
        #1 chk("jump_redirect", bus.redirect, 64'h1);
        step(); clr_upd();
        chk("jump_pc", bus.pc, 64'h300);
        set_upd(1, 0, 32'h80, 1, 32'h500, 0, 32'h0);
        step(); clr_upd();
        chk("alias_br_pc", bus.pc, 64'h500);
        chk("alias_cnt", bus.mispredict_cnt, 64'h7);
        set_upd(1, 0, 32'h3c, 0, 32'h0, 1, 32'h40);
        step(); clr_upd();
        chk("steer40c_pc", bus.pc, 64'h40);
        #1 chk("alias40_miss", bus.pred_taken, 64'h0);
        set_upd(1, 0, 32'h7c, 0, 32'h0, 1, 32'h80);
        step(); clr_upd();
        chk("steer80_pc", bus.pc, 64'h80);
        chk("steer80_cnt", bus.mispredict_cnt, 64'h9);
        #1 chk("hit80_pred", bus.pred_taken, 64'h1);
        chk("hit80_target", bus.pred_target, 64'h500);
        step(); chk("hit80_next_pc", bus.pc, 64'h500);

        // valid update with no type bits is ignored
        set_upd(0, 0, 32'h40, 1, 32'h900, 0, 32'h0);
        #1 chk("notype_redirect", bus.redirect, 64'h0);
        step(); clr_upd();
        chk("notype_pc", bus.pc, 64'h504);
        chk("notype_cnt", bus.mispredict_cnt, 64'h9);

        // same-cycle lookup and update on index of 0x80
        set_upd(1, 0, 32'h7c, 0, 32'h0, 1, 32'h80);
        step(); clr_upd();
        chk("steer80b_pc", bus.pc, 64'h80);
        set_upd(1, 0, 32'h80, 0, 32'h500, 1, 32'h500);
        #1 chk("same_cycle_pred", bus.pred_taken, 64'h1);
        chk("same_cycle_redirect", bus.redirect, 64'h1);
        step(); clr_upd();
        chk("same_cycle_pc", bus.pc, 64'h84);
        chk("same_cycle_cnt", bus.mispredict_cnt, 64'hb);

        // reset, then eight consecutive mispredicts
        rst = 1'b1;
        #1 chk("rst2_pc", bus.pc, 64'h0);
        chk("rst2_cnt", bus.mispredict_cnt, 64'h0);
        step();
        rst = 1'b0;
        set_upd(1, 0, 32'h7c, 0, 32'h0, 1, 32'h80);
        repeat (8) step();
        clr_upd();
        chk("eight_cnt", bus.mispredict_cnt, 64'h8);
        chk("eight_pc", bus.pc, 64'h80);

        // async reset mid-cycle while an allocating update is presented
        set_upd(1, 0, 32'h80, 1, 32'h700, 0, 32'h0);
        #3 rst = 1'b1;
        #1 chk("async_rst_pc", bus.pc, 64'h0);
        chk("async_rst_cnt", bus.mispredict_cnt, 64'h0);
        step(); clr_upd();
        rst = 1'b0;
        set_upd(1, 0, 32'h7c, 0, 32'h0, 1, 32'h80);
        step(); clr_upd();
        chk("post_rst_pc", bus.pc, 64'h80);
        chk("post_rst_cnt", bus.mispredict_cnt, 64'h1);
        #1 chk("post_rst_no_alloc", bus.pred_taken, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
